// File: rtl/cpu_pkg.sv
// Shared widths, instruction field positions, opcode values and the fetch state
// encoding used by the instruction fetch unit.
package cpu_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 16;

  localparam int CLASS_HI  = 15;
  localparam int CLASS_LO  = 14;
  localparam int OPCODE_HI = 13;
  localparam int OPCODE_LO = 9;

  // Full 7-bit {class, opcode} values
  localparam logic [6:0] OP_HALT    = 7'b11_11000;
  localparam logic [6:0] OP_DISPLAY = 7'b11_10110;
  localparam logic [6:0] OP_BRANCH  = 7'b10_10100;
  localparam logic [6:0] OP_ADDI    = 7'b00_00100;
  localparam logic [6:0] OP_LOAD    = 7'b01_00001;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

  function automatic logic [6:0] op_field(input logic [INSTR_W-1:0] instr);
    return instr[CLASS_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// Single-entry valid/ready output register between fetch and decode.
// A flush empties the slot and takes priority over a load.
module fetch_slot
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] data_in,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               ready,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // The payload only changes on load, so it stays stable while waiting on decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= data_in;
      pc    <= pc_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads instruction memory combinationally and
// hands words to decode through fetch_slot; handles redirects and stops on HALT.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [6:0]        HALT_CODE = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              capture;
  logic              flush;
  logic              slot_free;

  assign read_address = pc;
  assign slot_free    = !if_valid || if_ready;
  assign halted       = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Redirect outranks any capture, including a HALT word arriving the same cycle
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) pc_next = redirect_target;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          flush   = 1'b1;
        end else if (slot_free) begin
          capture = 1'b1;
          if (op_field(instruction_in) == HALT_CODE) state_next = HALT;
          else pc_next = pc + ADDR_W'(1);
        end
      end
      HALT: ;
      default: state_next = IDLE;
    endcase
  end

  fetch_slot u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (capture),
    .flush   (flush),
    .data_in (instruction_in),
    .pc_in   (pc),
    .ready   (if_ready),
    .valid   (if_valid),
    .instr   (if_instr),
    .pc      (if_pc)
  );

endmodule
